// File: rtl/hwag_pkg.sv
// hwag_pkg: shared types and constants for the HWAG coil scheduler.
//   coil_state_t  - per-channel coil FSM state
//   HWA_ACNT_W    - default angle count width
//   HWA_ACNT_MAX  - default last angle value before wrap to 0
package hwag_pkg;

    localparam int HWA_ACNT_W   = 24;
    localparam int HWA_ACNT_MAX = 3839;

    typedef enum logic [1:0] {
        OFF,
        ARMED,
        DWELL,
        HOLDOFF
    } coil_state_t;

endpackage

// File: rtl/hwag_coil_channel.sv
// hwag_coil_channel: one coil channel. Holds the FSM, the dwell timeout
// counter, the active/pending angle pairs and the commit logic.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   hwag_start        - generator synchronised; low forces the coil off
//   acnt, acnt_ena    - angle count and its new-value strobe
//   wr, wr_set/reset  - validated write of this channel's pending pair
//   max_dwell         - dwell limit in clk cycles (0 disables)
//   coil_out          - registered coil drive
//   overrun           - sticky dwell-timeout flag
//   pending           - pending pair not yet committed
module hwag_coil_channel
    import hwag_pkg::*;
#(
    parameter int ACNT_WIDTH = HWA_ACNT_W,
    parameter int TMO_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hwag_start,
    input  logic [ACNT_WIDTH-1:0] acnt,
    input  logic                  acnt_ena,
    input  logic                  wr,
    input  logic [ACNT_WIDTH-1:0] wr_set,
    input  logic [ACNT_WIDTH-1:0] wr_reset,
    input  logic [TMO_WIDTH-1:0]  max_dwell,
    output logic                  coil_out,
    output logic                  overrun,
    output logic                  pending
);

    coil_state_t           state_q, state_d;
    logic [ACNT_WIDTH-1:0] set_act, reset_act, set_pnd, reset_pnd;
    logic [TMO_WIDTH-1:0]  dwell_cnt;
    logic                  defer_q;

    logic wrap, set_hit, reset_hit, timeout, in_dwell, commit;

    assign wrap      = acnt_ena && (acnt == '0);
    // Equal set/reset angles mean the channel is disabled and never fires.
    assign set_hit   = acnt_ena && (acnt == set_act) && (set_act != reset_act);
    assign reset_hit = acnt_ena && (acnt == reset_act);
    assign timeout   = (max_dwell != '0) && (dwell_cnt == max_dwell);
    assign in_dwell  = (state_q == DWELL);

    // A coil is never re-timed mid-dwell: a wrap seen while dwelling is
    // remembered in defer_q and the commit happens once DWELL is left.
    assign commit = pending && (!hwag_start || (!in_dwell && (wrap || defer_q)));

    // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!hwag_start) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF:     state_d = ARMED;
                ARMED:   if (set_hit) state_d = DWELL;
                // The reset-angle match takes priority over a coincident timeout.
                DWELL:   if (reset_hit)    state_d = ARMED;
                         else if (timeout) state_d = HOLDOFF;
                HOLDOFF: if (reset_hit) state_d = ARMED;
                default: state_d = OFF;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the angle pair registers are reset too, because a
            // channel must come out of reset disabled (0/0), not with stale angles.
            state_q   <= OFF;
            coil_out  <= 1'b0;
            overrun   <= 1'b0;
            pending   <= 1'b0;
            defer_q   <= 1'b0;
            dwell_cnt <= '0;
            set_act   <= '0;
            reset_act <= '0;
            set_pnd   <= '0;
            reset_pnd <= '0;
        end else begin
            state_q  <= state_d;
            coil_out <= (state_d == DWELL);

            if (state_d == DWELL && !in_dwell) begin
                dwell_cnt <= '0;
            end else if (in_dwell && dwell_cnt != '1) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end

            if (!hwag_start || commit) begin
                defer_q <= 1'b0;
            end else if (wrap && in_dwell && pending) begin
                defer_q <= 1'b1;
            end

            // Commit first, write second: on a collision the active pair
            // takes the old pending pair and the new one stays pending.
            if (commit) begin
                set_act   <= set_pnd;
                reset_act <= reset_pnd;
                pending   <= 1'b0;
            end
            if (wr) begin
                set_pnd   <= wr_set;
                reset_pnd <= wr_reset;
                pending   <= 1'b1;
            end

            if (in_dwell && state_d == HOLDOFF) begin
                overrun <= 1'b1;
            end else if (wr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hwag_coil_sched.sv
// hwag_coil_sched: multi-channel coil driver downstream of the HWAG angle
// generator. Range-checks and decodes configuration writes and instantiates
// one hwag_coil_channel per coil.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   hwag_start            - generator synchronised; low forces all coils off
//   acnt, acnt_ena        - angle count and new-value strobe
//   cfg_wr, cfg_ch        - angle pair write strobe and target channel
//   cfg_set, cfg_reset    - set (dwell start) and reset (spark) angles
//   max_dwell             - shared dwell limit in clk cycles, 0 disables
//   coil_out, overrun     - coil drives and sticky timeout flags
//   cfg_pending, cfg_err  - uncommitted pairs and rejected-write pulse
module hwag_coil_sched
    import hwag_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int ACNT_WIDTH = HWA_ACNT_W,
    parameter int ACNT_MAX   = HWA_ACNT_MAX,
    parameter int TMO_WIDTH  = 24,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hwag_start,
    input  logic [ACNT_WIDTH-1:0] acnt,
    input  logic                  acnt_ena,
    input  logic                  cfg_wr,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [ACNT_WIDTH-1:0] cfg_set,
    input  logic [ACNT_WIDTH-1:0] cfg_reset,
    input  logic [TMO_WIDTH-1:0]  max_dwell,
    output logic [CHANNELS-1:0]   coil_out,
    output logic [CHANNELS-1:0]   overrun,
    output logic [CHANNELS-1:0]   cfg_pending,
    output logic                  cfg_err
);

    localparam logic [ACNT_WIDTH-1:0] ANGLE_LIMIT = ACNT_WIDTH'(ACNT_MAX);

    logic wr_ok;

    assign wr_ok = (cfg_set <= ANGLE_LIMIT) && (cfg_reset <= ANGLE_LIMIT) &&
                   (32'(cfg_ch) < 32'(CHANNELS));

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !wr_ok;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr_ch;
        assign wr_ch = cfg_wr && wr_ok && (cfg_ch == CH_W'(i));

        hwag_coil_channel #(
            .ACNT_WIDTH (ACNT_WIDTH),
            .TMO_WIDTH  (TMO_WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .hwag_start (hwag_start),
            .acnt       (acnt),
            .acnt_ena   (acnt_ena),
            .wr         (wr_ch),
            .wr_set     (cfg_set),
            .wr_reset   (cfg_reset),
            .max_dwell  (max_dwell),
            .coil_out   (coil_out[i]),
            .overrun    (overrun[i]),
            .pending    (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_hwag_coil_sched.sv
// tb_hwag_coil_sched: directed, self-checking bench for hwag_coil_sched.
// A vector table covers reset release, the write path and a first dwell;
// hand-written sequences cover wrap sweeps, deferred/colliding commits,
// dwell timeout, hwag_start drop and reset mid-dwell.
module tb_hwag_coil_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hwag_start = 1'b0;
    logic [23:0] acnt = '0;
    logic        acnt_ena = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [23:0] cfg_set = '0;
    logic [23:0] cfg_reset = '0;
    logic [23:0] max_dwell = '0;
    logic [3:0]  coil_out, overrun, cfg_pending;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    hwag_coil_sched #(
        .CHANNELS   (4),
        .ACNT_WIDTH (24),
        .ACNT_MAX   (3839),
        .TMO_WIDTH  (24)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hwag_start  (hwag_start),
        .acnt        (acnt),
        .acnt_ena    (acnt_ena),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_set     (cfg_set),
        .cfg_reset   (cfg_reset),
        .max_dwell   (max_dwell),
        .coil_out    (coil_out),
        .overrun     (overrun),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        start;
        logic [23:0] acnt;
        logic        ena;
        logic        wr;
        logic [1:0]  ch;
        logic [23:0] set_ang;
        logic [23:0] reset_ang;
        logic [3:0]  exp_coil;
        logic [3:0]  exp_pend;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int a);
        acnt     = 24'(a);
        acnt_ena = 1'b1;
        tick();
        acnt_ena = 1'b0;
    endtask

    task automatic write(input int ch, input int s, input int r);
        cfg_wr    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_set   = 24'(s);
        cfg_reset = 24'(r);
        tick();
        cfg_wr    = 1'b0;
    endtask

    // Full angle cycle; ch0 uses 100/200, ch1 uses 3800/40 (only high
    // below 40 once it has already risen in a previous cycle).
    task automatic sweep(input bit first, output int errs);
        logic [3:0] e;
        errs = 0;
        for (int a = 0; a <= 3839; a++) begin
            strobe(a);
            e    = '0;
            e[0] = (a >= 100) && (a < 200);
            e[1] = (a >= 3800) || (!first && a < 40);
            if (coil_out !== e) errs++;
        end
    endtask

    initial begin
        int errs;
        int fall_n;
        int ang;

        //              start acnt ena wr ch set   reset coil pend err
        vecs[0]  = '{1'b0,    0, 0, 0, 0,    0,    0, 4'h0, 4'h0, 1'b0};
        vecs[1]  = '{1'b0,    0, 0, 1, 0,  100,  200, 4'h0, 4'h1, 1'b0};
        vecs[2]  = '{1'b0,    0, 0, 0, 0,    0,    0, 4'h0, 4'h0, 1'b0};
        vecs[3]  = '{1'b0,    0, 0, 1, 0, 3840,    5, 4'h0, 4'h0, 1'b1};
        vecs[4]  = '{1'b0,    0, 0, 0, 0,    0,    0, 4'h0, 4'h0, 1'b0};
        vecs[5]  = '{1'b0,    0, 0, 1, 0,   10, 3840, 4'h0, 4'h0, 1'b1};
        vecs[6]  = '{1'b0,    0, 0, 1, 1, 3800,   40, 4'h0, 4'h2, 1'b0};
        vecs[7]  = '{1'b0,    0, 0, 1, 2, 3839, 3839, 4'h0, 4'h4, 1'b0};
        vecs[8]  = '{1'b0,    0, 0, 0, 0,    0,    0, 4'h0, 4'h0, 1'b0};
        vecs[9]  = '{1'b1,    0, 0, 0, 0,    0,    0, 4'h0, 4'h0, 1'b0};
        vecs[10] = '{1'b1,  100, 1, 0, 0,    0,    0, 4'h1, 4'h0, 1'b0};
        vecs[11] = '{1'b1,  150, 1, 0, 0,    0,    0, 4'h1, 4'h0, 1'b0};
        vecs[12] = '{1'b1,  200, 1, 0, 0,    0,    0, 4'h0, 4'h0, 1'b0};

        // Reset state.
        tick();
        tick();
        check("reset_state", {coil_out, overrun, cfg_pending, 3'b0, cfg_err}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            hwag_start = vecs[i].start;
            acnt       = vecs[i].acnt;
            acnt_ena   = vecs[i].ena;
            cfg_wr     = vecs[i].wr;
            cfg_ch     = vecs[i].ch;
            cfg_set    = vecs[i].set_ang;
            cfg_reset  = vecs[i].reset_ang;
            tick();
            check($sformatf("vec%0d_coil", i), 32'(coil_out), 32'(vecs[i].exp_coil));
            check($sformatf("vec%0d_pend", i), 32'(cfg_pending), 32'(vecs[i].exp_pend));
            check($sformatf("vec%0d_err", i), 32'(cfg_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'h0);
        end
        acnt_ena = 1'b0;
        cfg_wr   = 1'b0;

        // Two full cycles: ch0 100..200, ch1 across the wrap.
        sweep(1'b1, errs);
        check("sweep1_errors", 32'(errs), 32'd0);
        sweep(1'b0, errs);
        check("sweep2_errors", 32'(errs), 32'd0);

        // ch1 is dwelling (3800..): write defers past the wrap.
        write(1, 500, 600);
        check("defer_pend", 32'(cfg_pending), 32'h2);
        strobe(0);
        check("defer_wrap_coil", 32'(coil_out), 32'h2);
        check("defer_wrap_pend", 32'(cfg_pending), 32'h2);
        strobe(40);
        check("defer_fall_coil", 32'(coil_out), 32'h0);
        check("defer_fall_pend", 32'(cfg_pending), 32'h2);
        tick();
        check("defer_commit_pend", 32'(cfg_pending), 32'h0);
        strobe(500);
        check("ch1_new_rise", 32'(coil_out), 32'h2);
        strobe(600);
        check("ch1_new_fall", 32'(coil_out), 32'h0);
        strobe(3800);
        check("ch1_old_gone", 32'(coil_out), 32'h0);

        // ch0 write mid-dwell: old pair keeps driving, commit at next wrap.
        strobe(100);
        check("ch0_rise", 32'(coil_out), 32'h1);
        write(0, 500, 600);
        check("ch0_wr_pend", 32'(cfg_pending), 32'h1);
        check("ch0_wr_coil", 32'(coil_out), 32'h1);
        strobe(200);
        check("ch0_old_fall", 32'(coil_out), 32'h0);
        check("ch0_pend_held", 32'(cfg_pending), 32'h1);
        strobe(500);
        check("ch0_not_yet", 32'(coil_out), 32'h2);
        strobe(600);
        strobe(0);
        check("ch0_commit_pend", 32'(cfg_pending), 32'h0);
        strobe(100);
        check("ch0_old_set_gone", 32'(coil_out), 32'h0);
        strobe(500);
        check("ch0_ch1_rise", 32'(coil_out), 32'h3);
        strobe(600);
        check("ch0_ch1_fall", 32'(coil_out), 32'h0);

        // Write colliding with the wrap commit on ch0.
        write(0, 700, 800);
        acnt = 24'd0; acnt_ena = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_set = 24'd900; cfg_reset = 24'd1000;
        tick();
        acnt_ena = 1'b0; cfg_wr = 1'b0;
        check("collide_pend", 32'(cfg_pending), 32'h1);
        strobe(700);
        check("collide_active_rise", 32'(coil_out), 32'h1);
        strobe(800);
        check("collide_active_fall", 32'(coil_out), 32'h0);
        strobe(900);
        check("collide_new_idle", 32'(coil_out), 32'h0);

        // Rejected write leaves the pending pair alone.
        write(0, 3840, 0);
        check("bad_set_err", 32'(cfg_err), 32'h1);
        check("bad_set_pend", 32'(cfg_pending), 32'h1);
        tick();
        check("bad_set_err_pulse", 32'(cfg_err), 32'h0);

        // Timeout setup: ch2 0/20, everything else disabled.
        hwag_start = 1'b0;
        tick();
        write(0, 0, 0);
        write(1, 0, 0);
        write(2, 0, 20);
        tick();
        check("to_setup_pend", 32'(cfg_pending), 32'h0);
        max_dwell  = 24'd50;
        hwag_start = 1'b1;
        tick();
        strobe(0);
        check("to_rise", 32'(coil_out), 32'h4);
        fall_n = 0;
        ang    = 1;
        for (int n = 1; n <= 60; n++) begin
            if (n % 10 == 0) begin
                acnt = 24'(ang); acnt_ena = 1'b1; ang++;
            end
            tick();
            acnt_ena = 1'b0;
            if (fall_n == 0 && coil_out[2] == 1'b0) fall_n = n;
        end
        check("to_fall_cycles", 32'(fall_n), 32'd51);
        check("to_overrun", 32'(overrun), 32'h4);
        errs = 0;
        for (int a = 7; a <= 19; a++) begin
            strobe(a);
            if (coil_out !== 4'h0) errs++;
        end
        strobe(0);
        if (coil_out !== 4'h0) errs++;
        check("holdoff_quiet", 32'(errs), 32'd0);
        strobe(20);
        check("holdoff_release", 32'(coil_out), 32'h0);
        strobe(0);
        check("rearm_rise", 32'(coil_out), 32'h4);
        strobe(20);
        check("rearm_fall", 32'(coil_out), 32'h0);
        check("overrun_sticky", 32'(overrun), 32'h4);
        write(2, 0, 20);
        check("overrun_cleared", 32'(overrun), 32'h0);

        // Reset-angle strobe coincident with the timeout: match wins.
        strobe(0);
        check("tie_rise", 32'(coil_out), 32'h4);
        for (int n = 1; n <= 50; n++) tick();
        check("tie_still_high", 32'(coil_out), 32'h4);
        strobe(20);
        check("tie_fall", 32'(coil_out), 32'h0);
        check("tie_no_overrun", 32'(overrun), 32'h0);
        strobe(0);
        check("tie_armed_rise", 32'(coil_out), 32'h4);

        // hwag_start dropped mid-dwell.
        hwag_start = 1'b0;
        tick();
        check("start_drop", 32'(coil_out), 32'h0);
        hwag_start = 1'b1;
        tick();

        // Reset mid-dwell with overrun and a pending write outstanding.
        strobe(0);
        for (int n = 1; n <= 51; n++) tick();
        check("pre_rst_overrun", 32'(overrun), 32'h4);
        strobe(20);
        strobe(0);
        write(1, 5, 6);
        check("pre_rst_state", {coil_out, overrun, cfg_pending}, 32'h442);
        rst = 1'b1;
        tick();
        check("rst_mid_dwell", {coil_out, overrun, cfg_pending, 3'b0, cfg_err}, 32'h0);
        rst = 1'b0;
        tick();
        strobe(0);
        check("rst_cleared_ch2", 32'(coil_out), 32'h0);
        strobe(5);
        check("rst_cleared_ch1", 32'(coil_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
